// File: rtl/regfile_mp_if.sv
// regfile_mp port bundle: write ports, read ports and read data.
// Multi-port signals are packed per port, port j at [j*W +: W].
interface regfile_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 1
);
  logic [NW-1:0]          WEN;
  logic [NW*AW-1:0]       WA;
  logic [NW*(DW/8)-1:0]   WBE;
  logic [NW*DW-1:0]       DI;
  logic [NR-1:0]          REN;
  logic [NR*AW-1:0]       RA;
  logic [NR*DW-1:0]       DOUT;

  modport master (
    output WEN,
    output WA,
    output WBE,
    output DI,
    output REN,
    output RA,
    input  DOUT
  );

  modport slave (
    input  WEN,
    input  WA,
    input  WBE,
    input  DI,
    input  REN,
    input  RA,
    output DOUT
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte strobes,
// optional zero entry, write bypass and optional registered read.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ENTRY    = 32,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic         CLK,
  input  logic         RSTN,
  regfile_mp_if.slave  bus
);
  localparam int NB = DW / 8;
  localparam int IW = (ENTRY > 1) ? $clog2(ENTRY) : 1;

  logic [DW-1:0] mem   [ENTRY];
  logic [AW-1:0] wa    [NW];
  logic [NB-1:0] wbe   [NW];
  logic [DW-1:0] wd    [NW];
  logic [NW-1:0] wok;
  logic [AW-1:0] ra    [NR];
  logic [DW-1:0] rdata [NR];

  // Address maps to a real, writable/readable entry.
  function automatic logic legal(
    input logic [AW-1:0] a
  );
    logic in_rng;
    logic is_zero;
    in_rng  = int'(a) < ENTRY;
    is_zero = (ZERO_REG != 0) && (a == '0);
    return in_rng && !is_zero;
  endfunction

  // Unpack write ports and qualify each one.
  always_comb begin
    for (int j = 0; j < NW; j++) begin
      wa[j]  = bus.WA[j*AW +: AW];
      wbe[j] = bus.WBE[j*NB +: NB];
      wd[j]  = bus.DI[j*DW +: DW];
      wok[j] = !bus.WEN[j] && legal(wa[j]);
    end
  end

  // Storage: ascending port order, so the highest
  // strobed port owns each contested byte.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int e = 0; e < ENTRY; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        for (int b = 0; b < NB; b++) begin
          if (wok[j] && wbe[j][b]) begin
            mem[wa[j][IW-1:0]][b*8 +: 8] <=
              wd[j][b*8 +: 8];
          end
        end
      end
    end
  end

  // Read select with per-byte write-first override.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      ra[i]    = bus.RA[i*AW +: AW];
      rdata[i] = '0;
      if (legal(ra[i])) begin
        rdata[i] = mem[ra[i][IW-1:0]];
      end
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          for (int b = 0; b < NB; b++) begin
            if (wok[j] && wbe[j][b] &&
                wa[j] == ra[i]) begin
              rdata[i][b*8 +: 8] = wd[j][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  generate
    if (RD_REG != 0) begin : g_rreg
      logic [DW-1:0] dq [NR];

      // Output registers, loaded on active-low REN.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          for (int i = 0; i < NR; i++) begin
            dq[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NR; i++) begin
            if (!bus.REN[i]) begin
              dq[i] <= rdata[i];
            end
          end
        end
      end

      // Pack registered read data.
      always_comb begin
        bus.DOUT = '0;
        for (int i = 0; i < NR; i++) begin
          bus.DOUT[i*DW +: DW] = dq[i];
        end
      end
    end else begin : g_rasync
      logic unused_ren;
      assign unused_ren = ^bus.REN;

      // Pack combinational read data.
      always_comb begin
        bus.DOUT = '0;
        for (int i = 0; i < NR; i++) begin
          bus.DOUT[i*DW +: DW] = rdata[i];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three configurations driven
// together and checked against a byte-level reference model.
module tb_regfile_mp;
  typedef logic [2:0][63:0] exp_t;

  logic CLK = 1'b0;
  logic RSTN;
  logic msamp;

  always #5 CLK = ~CLK;

  regfile_mp_if #(.NW(1)) if0 ();
  regfile_mp_if #(.NW(2)) if1 ();
  regfile_mp_if #(.NW(2)) if2 ();

  regfile_mp dut0 (
    .CLK(CLK), .RSTN(RSTN), .bus(if0.slave)
  );
  regfile_mp #(
    .ENTRY(24), .NW(2), .RD_REG(1)
  ) dut1 (
    .CLK(CLK), .RSTN(RSTN), .bus(if1.slave)
  );
  regfile_mp #(
    .NW(2), .ZERO_REG(0), .BYPASS(0)
  ) dut2 (
    .CLK(CLK), .RSTN(RSTN), .bus(if2.slave)
  );

  int ent [3] = '{32, 24, 32};
  int nwp [3] = '{1, 2, 2};
  bit zr  [3] = '{1'b1, 1'b1, 1'b0};
  bit bp  [3] = '{1'b1, 1'b1, 1'b0};
  bit rr  [3] = '{1'b0, 1'b1, 1'b0};

  logic        wen [3][2];
  logic [4:0]  wa  [3][2];
  logic [3:0]  wbe [3][2];
  logic [31:0] di  [3][2];
  logic        ren [3][2];
  logic [4:0]  ra  [3][2];

  assign if0.WEN = wen[0][0];
  assign if0.WA  = wa[0][0];
  assign if0.WBE = wbe[0][0];
  assign if0.DI  = di[0][0];
  assign if0.REN = {ren[0][1], ren[0][0]};
  assign if0.RA  = {ra[0][1], ra[0][0]};
  assign if1.WEN = {wen[1][1], wen[1][0]};
  assign if1.WA  = {wa[1][1], wa[1][0]};
  assign if1.WBE = {wbe[1][1], wbe[1][0]};
  assign if1.DI  = {di[1][1], di[1][0]};
  assign if1.REN = {ren[1][1], ren[1][0]};
  assign if1.RA  = {ra[1][1], ra[1][0]};
  assign if2.WEN = {wen[2][1], wen[2][0]};
  assign if2.WA  = {wa[2][1], wa[2][0]};
  assign if2.WBE = {wbe[2][1], wbe[2][0]};
  assign if2.DI  = {di[2][1], di[2][0]};
  assign if2.REN = {ren[2][1], ren[2][0]};
  assign if2.RA  = {ra[2][1], ra[2][0]};

  logic [63:0] dout [3];
  assign dout[0] = if0.DOUT;
  assign dout[1] = if1.DOUT;
  assign dout[2] = if2.DOUT;

  logic [31:0] mem  [3][32];
  logic [31:0] dreg [3][2];
  exp_t q [$];
  int   idq [$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic bit legal_a(int k, logic [4:0] a);
    return (int'(a) < ent[k]) && !(zr[k] && a == 5'd0);
  endfunction

  function automatic bit wok(int k, int j);
    return j < nwp[k] && !wen[k][j] && legal_a(k, wa[k][j]);
  endfunction

  function automatic logic [31:0] rd(int k, logic [4:0] a);
    logic [31:0] r;
    r = '0;
    if (legal_a(k, a)) r = mem[k][a];
    if (bp[k]) begin
      for (int j = 0; j < 2; j++) begin
        for (int b = 0; b < 4; b++) begin
          if (wok(k, j) && wa[k][j] == a && wbe[k][j][b])
            r[8*b +: 8] = di[k][j][8*b +: 8];
        end
      end
    end
    return r;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rr[k]) e[k] = {dreg[k][1], dreg[k][0]};
      else e[k] = {rd(k, ra[k][1]), rd(k, ra[k][0])};
    end
    return e;
  endfunction

  task automatic clr_model();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) mem[k][a] = '0;
      dreg[k][0] = '0;
      dreg[k][1] = '0;
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        wen[k][j] = 1'b1;
        wa[k][j]  = '0;
        wbe[k][j] = '0;
        di[k][j]  = '0;
        ren[k][j] = 1'b1;
        ra[k][j]  = '0;
      end
    end
  endtask

  task automatic wr(int k, int j, logic [4:0] a,
                    logic [31:0] d, logic [3:0] be);
    wen[k][j] = 1'b0;
    wa[k][j]  = a;
    di[k][j]  = d;
    wbe[k][j] = be;
  endtask

  task automatic rdp(int k, int i, logic [4:0] a);
    ra[k][i]  = a;
    ren[k][i] = 1'b0;
  endtask

  task automatic push();
    q.push_back(expect_now());
    idq.push_back(cyc);
  endtask

  // Advance one edge: registered reads see pre-write state
  // (plus bypass), then the writes land.
  task automatic tick();
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rr[k]) begin
        for (int i = 0; i < 2; i++)
          if (!ren[k][i]) dreg[k][i] = rd(k, ra[k][i]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        for (int b = 0; b < 4; b++) begin
          if (wok(k, j) && wbe[k][j][b])
            mem[k][wa[k][j]][8*b +: 8] = di[k][j][8*b +: 8];
        end
      end
    end
    cyc++;
  endtask

  task automatic rst_pulse();
    @(negedge CLK);
    #1;
    RSTN = 1'b0;
    clr_model();
    push();
    #1 msamp = 1'b1;
    #1 msamp = 1'b0;
    RSTN = 1'b1;
  endtask

  // Monitor: compare on every negedge or explicit mid-cycle sample.
  initial begin : mon
    exp_t e;
    int   id;
    forever begin
      @(negedge CLK or posedge msamp);
      if (q.size() > 0) begin
        e  = q.pop_front();
        id = idq.pop_front();
        for (int k = 0; k < 3; k++) begin
          tests++;
          if (dout[k] !== e[k]) begin
            fails++;
            $display("FAIL dout_dut%0d cyc%0d: got %h expected %h",
                     k, id, dout[k], e[k]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RSTN  = 1'b0;
    msamp = 1'b0;
    idle();
    clr_model();
    #1 push();
    #1 msamp = 1'b1;
    #1 msamp = 1'b0;
    RSTN = 1'b1;

    tick(); idle(); push();
    // reset clear
    tick(); idle(); wr(0, 0, 5, 32'hDEADBEEF, 4'hF);
    rdp(0, 0, 5); push();
    tick(); idle(); rdp(0, 0, 5); push();
    rst_pulse();
    // byte strobes
    tick(); idle(); wr(0, 0, 3, 32'h11223344, 4'hF);
    wr(2, 0, 3, 32'h11223344, 4'hF); push();
    tick(); idle(); wr(0, 0, 3, 32'hAABBCCDD, 4'b0101);
    wr(2, 0, 3, 32'hAABBCCDD, 4'b0101);
    rdp(0, 0, 3); rdp(2, 0, 3); push();
    tick(); idle(); rdp(0, 0, 3); rdp(2, 1, 3); push();
    // zero entry and out of range
    tick(); idle(); wr(0, 0, 0, 32'hFFFFFFFF, 4'hF);
    wr(1, 0, 30, 32'h12345678, 4'hF);
    wr(1, 1, 2, 32'h0BADF00D, 4'hF);
    rdp(0, 1, 0); rdp(1, 0, 30); push();
    tick(); idle(); rdp(0, 1, 0); rdp(1, 0, 30);
    rdp(1, 1, 2); push();
    tick(); idle(); push();
    // bypass vs read-first
    tick(); idle(); wr(0, 0, 7, 32'h1, 4'hF);
    wr(2, 0, 7, 32'h1, 4'hF); push();
    tick(); idle(); wr(0, 0, 7, 32'h2, 4'hF);
    wr(2, 0, 7, 32'h2, 4'hF);
    rdp(0, 1, 7); rdp(2, 1, 7); push();
    tick(); idle(); rdp(0, 1, 7); rdp(2, 1, 7); push();
    // multi-write conflict
    tick(); idle();
    for (int k = 1; k < 3; k++) wr(k, 0, 9, 32'h0, 4'hF);
    push();
    tick(); idle();
    for (int k = 1; k < 3; k++) begin
      wr(k, 0, 9, 32'h0000FFFF, 4'hF);
      wr(k, 1, 9, 32'hAAAAAAAA, 4'b1100);
      rdp(k, 0, 9);
    end
    push();
    tick(); idle(); rdp(1, 1, 9); rdp(2, 1, 9); push();
    tick(); idle(); push();
    // registered read, write-first then hold
    tick(); idle(); wr(1, 0, 4, 32'h55, 4'hF);
    rdp(1, 0, 4); push();
    tick(); idle(); ra[1][0] = 5'd6; push();
    tick(); idle(); push();
    rst_pulse();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 2; j++) begin
          wen[k][j] = ($urandom_range(0, 2) == 0);
          wa[k][j]  = ($urandom_range(0, 3) == 0) ?
                      5'($urandom_range(0, 31)) :
                      5'($urandom_range(0, 9));
          wbe[k][j] = 4'($urandom_range(0, 15));
          di[k][j]  = $urandom;
          ren[k][j] = ($urandom_range(0, 3) == 0);
          ra[k][j]  = ($urandom_range(0, 3) == 0) ?
                      5'($urandom_range(0, 31)) :
                      5'($urandom_range(0, 9));
        end
      end
      push();
      if (n % 200 == 150) rst_pulse();
    end

    tick(); idle(); push();
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
